vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 183 ++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and colour from a sampled VGA stream.
// Coordinates are rebuilt from HS/VS falling edges; pixels are only reported once timing is locked.
module vga_sync_decoder #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned H_TOTAL   = 800,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned V_TOTAL   = 525
) (
   input  logic        pixel_clk,
   input  logic        reset,
   input  logic [3:0]  VGA_R,
   input  logic [3:0]  VGA_G,
   input  logic [3:0]  VGA_B,
   input  logic        VGA_HS,
   input  logic        VGA_VS,
   output logic [9:0]  X_pix,
   output logic [9:0]  Y_pix,
   output logic        pix_valid,
   output logic [11:0] pixel_color,
   output logic        locked,
   output logic        frame_start,
   output logic        sync_err
);

   localparam int unsigned H_START = H_SYNC + H_BACK;
   localparam int unsigned H_END   = H_START + H_VISIBLE - 1;
   localparam int unsigned V_START = V_SYNC + V_BACK;
   localparam int unsigned V_END   = V_START + V_VISIBLE - 1;
   localparam logic [9:0]  CNT_MAX = '1;
   localparam logic [9:0]  CNT_PRE = 10'd1022;

   typedef enum logic [1:0] {ST_SEARCH, ST_CHECK, ST_LOCKED} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_sync_err;

   logic [3:0]  r_red;
   logic [3:0]  r_grn;
   logic [3:0]  r_blu;
   logic        r_hs;
   logic        r_vs;
   logic        r_hs_d;
   logic        r_vs_d;
   logic        r_edge_en;
   logic [11:0] r_col_d;

   logic [9:0]  r_h_cnt;
   logic [9:0]  r_v_cnt;
   logic        r_vs_pend;

   logic        w_hs_fall;
   logic        w_vs_fall;
   logic        w_consume;
   logic        w_line_err;
   logic        w_frame_err;
   logic        w_err;
   logic        w_in_window;
   logic        w_active;
   logic [9:0]  w_x;
   logic [9:0]  w_y;

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         r_red     <= '0;
         r_grn     <= '0;
         r_blu     <= '0;
         r_hs      <= 1'b0;
         r_vs      <= 1'b0;
         r_hs_d    <= 1'b0;
         r_vs_d    <= 1'b0;
         r_edge_en <= 1'b0;
      end else begin
         r_red     <= VGA_R;
         r_grn     <= VGA_G;
         r_blu     <= VGA_B;
         r_hs      <= VGA_HS;
         r_vs      <= VGA_VS;
         r_hs_d    <= r_hs;
         r_vs_d    <= r_vs;
         r_edge_en <= 1'b1;
      end
   end

   assign w_hs_fall = r_edge_en & r_hs_d & ~r_hs;
   assign w_vs_fall = r_edge_en & r_vs_d & ~r_vs;
   // A VS fall on the same cycle as an HS fall is consumed immediately.
   assign w_consume = w_hs_fall & (r_vs_pend | w_vs_fall);

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         r_h_cnt   <= '0;
         r_v_cnt   <= '0;
         r_vs_pend <= 1'b0;
      end else begin
         if (w_hs_fall)
            r_h_cnt <= '0;
         else if (r_h_cnt != CNT_MAX)
            r_h_cnt <= r_h_cnt + 10'd1;

         if (w_consume) begin
            r_v_cnt   <= '0;
            r_vs_pend <= 1'b0;
         end else begin
            if (w_hs_fall && r_v_cnt != CNT_MAX)
               r_v_cnt <= r_v_cnt + 10'd1;
            if (w_vs_fall)
               r_vs_pend <= 1'b1;
         end
      end
   end

   assign w_line_err  = (w_hs_fall && (32'(r_h_cnt) + 32'd1 != H_TOTAL)) ||
                        (!w_hs_fall && r_h_cnt == CNT_PRE);
   assign w_frame_err = (w_consume && (32'(r_v_cnt) + 32'd1 != V_TOTAL)) ||
                        (w_hs_fall && !w_consume && r_v_cnt == CNT_PRE);
   assign w_err       = w_line_err | w_frame_err;

   always_ff @(posedge pixel_clk) begin
      if (reset)
         r_state <= ST_SEARCH;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_sync_err = 1'b0;
      case (r_state)
         ST_SEARCH: begin
            if (w_consume)
               w_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (w_err)
               w_next = ST_SEARCH;
            else if (w_consume)
               w_next = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (w_err) begin
               w_next     = ST_SEARCH;
               w_sync_err = 1'b1;
            end
         end
         default: w_next = ST_SEARCH;
      endcase
   end

   // Counters hold the position of the sample now in r_col_d, giving two-cycle colour latency.
   assign w_in_window = (32'(r_h_cnt) >= H_START) && (32'(r_h_cnt) <= H_END) &&
                        (32'(r_v_cnt) >= V_START) && (32'(r_v_cnt) <= V_END);
   assign w_active    = w_in_window && (r_state == ST_LOCKED);
   assign w_x         = r_h_cnt - 10'(H_START);
   assign w_y         = r_v_cnt - 10'(V_START);

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         r_col_d     <= '0;
         X_pix       <= '0;
         Y_pix       <= '0;
         pix_valid   <= 1'b0;
         pixel_color <= '0;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         r_col_d     <= {r_blu, r_grn, r_red};
         X_pix       <= w_active ? w_x : '0;
         Y_pix       <= w_active ? w_y : '0;
         pix_valid   <= w_active;
         pixel_color <= w_active ? r_col_d : '0;
         locked      <= (w_next == ST_LOCKED);
         frame_start <= w_active && (w_x == '0) && (w_y == '0);
         sync_err    <= w_sync_err;
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a shrunken 16x6 timing (28 clocks/line, 14 lines/frame).
module tb_vga_sync_decoder;

   localparam int HT  = 28;
   localparam int HSW = 4;
   localparam int HST = 7;
   localparam int VT  = 14;
   localparam int VSW = 2;
   localparam logic [9:0] X_LAST = 10'd15;
   localparam logic [9:0] Y_LAST = 10'd5;

   logic        pixel_clk = 1'b0;
   logic        reset     = 1'b1;
   logic [3:0]  VGA_R = '0;
   logic [3:0]  VGA_G = '0;
   logic [3:0]  VGA_B = '0;
   logic        VGA_HS = 1'b1;
   logic        VGA_VS = 1'b1;
   logic [9:0]  X_pix;
   logic [9:0]  Y_pix;
   logic        pix_valid;
   logic [11:0] pixel_color;
   logic        locked;
   logic        frame_start;
   logic        sync_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int fs_cnt = 0, fs_cyc = -1, serr_cnt = 0, serr_cyc = -1, lock_cyc = -1;
   int val_cnt = 0, xr_cnt = 0, yb_cnt = 0, viol = 0;
   logic [9:0]  fs_x = '0;
   logic [9:0]  fs_y = '0;
   logic [11:0] fs_col = '0;
   logic        prev_locked = 1'b0;
   int line_start_cyc [16];
   int tag_cyc = -1;

   vga_sync_decoder #(
      .H_VISIBLE(16), .H_SYNC(4), .H_BACK(3), .H_TOTAL(28),
      .V_VISIBLE(6),  .V_SYNC(2), .V_BACK(3), .V_TOTAL(14)
   ) dut (
      .pixel_clk(pixel_clk), .reset(reset),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .X_pix(X_pix), .Y_pix(Y_pix), .pix_valid(pix_valid),
      .pixel_color(pixel_color), .locked(locked),
      .frame_start(frame_start), .sync_err(sync_err)
   );

   always #5 pixel_clk = ~pixel_clk;

   always @(posedge pixel_clk) cyc <= cyc + 1;

   // Event recorder: samples outputs shortly after each rising edge.
   always @(posedge pixel_clk) begin
      #2;
      if (frame_start) begin
         fs_cnt++;
         fs_cyc = cyc;
         fs_x   = X_pix;
         fs_y   = Y_pix;
         fs_col = pixel_color;
      end
      if (sync_err) begin
         serr_cnt++;
         serr_cyc = cyc;
      end
      if (locked && !prev_locked) lock_cyc = cyc;
      prev_locked = locked;
      if (pix_valid) begin
         val_cnt++;
         if (X_pix == X_LAST) xr_cnt++;
         if (Y_pix == Y_LAST) yb_cnt++;
         if (X_pix > X_LAST || Y_pix > Y_LAST) viol++;
      end else if (pixel_color != 12'h000) begin
         viol++;
      end
      if (frame_start !== (pix_valid && X_pix == 10'd0 && Y_pix == 10'd0)) viol++;
   end

   task automatic drive(input logic hs, input logic vs, input logic [11:0] col);
      @(negedge pixel_clk);
      VGA_HS = hs;
      VGA_VS = vs;
      VGA_B  = col[11:8];
      VGA_G  = col[7:4];
      VGA_R  = col[3:0];
   endtask

   task automatic send_frame(input int vs_ofs, input int long_line, input int tag_l,
                             input int abort_l, input int abort_h);
      for (int l = 0; l < VT; l++) begin
         int len;
         len = (l == long_line) ? HT + 1 : HT;
         for (int h = 0; h < len; h++) begin
            int p;
            logic [11:0] col;
            if (l == abort_l && h == abort_h) return;
            p   = l * HT + h;
            col = (l == tag_l && h == HST) ? 12'hABC : 12'h5A5;
            drive(h >= HSW, !(p >= vs_ofs && p < vs_ofs + VSW * HT), col);
            if (h == 0) line_start_cyc[l] = cyc;
            if (l == tag_l && h == HST) tag_cyc = cyc;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) drive(1'b1, 1'b1, 12'h000);
      reset = 1'b0;
      repeat (4) drive(1'b1, 1'b1, 12'h000);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) drive(i[0], ~i[0], 12'hFFF);
      total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", pix_valid); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %0b want 0", locked); end
      total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rst_sync_err: got %0b want 0", sync_err); end
      total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs: got %0b want 0", frame_start); end
      total++; if (pixel_color !== 12'h000) begin bad++; $display("FAIL rst_color: got %h want 000", pixel_color); end
      total++; if (X_pix !== 10'd0) begin bad++; $display("FAIL rst_x: got %0d want 0", X_pix); end
      total++; if (Y_pix !== 10'd0) begin bad++; $display("FAIL rst_y: got %0d want 0", Y_pix); end
      reset = 1'b0;
      repeat (6) drive(1'b1, 1'b1, 12'h5A5);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL idle_locked: got %0b want 0", locked); end
      total++; if (serr_cnt !== 0) begin bad++; $display("FAIL idle_serr: got %0d want 0", serr_cnt); end
   endtask

   task automatic test_lock();
      send_frame(0, -1, 5, -1, -1);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_f1_locked: got %0b want 0", locked); end
      total++; if (fs_cnt !== 0) begin bad++; $display("FAIL lock_f1_fs: got %0d want 0", fs_cnt); end
      send_frame(0, -1, 5, -1, -1);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_f2_locked: got %0b want 1", locked); end
      total++; if (lock_cyc !== line_start_cyc[0] + 2) begin bad++; $display("FAIL lock_time: got %0d want %0d", lock_cyc, line_start_cyc[0] + 2); end
      total++; if (fs_cnt !== 1) begin bad++; $display("FAIL lock_f2_fs: got %0d want 1", fs_cnt); end
      total++; if (serr_cnt !== 0) begin bad++; $display("FAIL lock_serr: got %0d want 0", serr_cnt); end
   endtask

   task automatic test_pixel();
      int f0, v0, x0, y0;
      f0 = fs_cnt; v0 = val_cnt; x0 = xr_cnt; y0 = yb_cnt;
      send_frame(0, -1, 5, -1, -1);
      total++; if (fs_cnt !== f0 + 1) begin bad++; $display("FAIL px_fs_cnt: got %0d want %0d", fs_cnt, f0 + 1); end
      total++; if (fs_cyc !== tag_cyc + 3) begin bad++; $display("FAIL px_latency: got %0d want %0d", fs_cyc, tag_cyc + 3); end
      total++; if (fs_col !== 12'hABC) begin bad++; $display("FAIL px_color: got %h want abc", fs_col); end
      total++; if (fs_x !== 10'd0) begin bad++; $display("FAIL px_x0: got %0d want 0", fs_x); end
      total++; if (fs_y !== 10'd0) begin bad++; $display("FAIL px_y0: got %0d want 0", fs_y); end
      total++; if (val_cnt - v0 !== 96) begin bad++; $display("FAIL px_valid_cnt: got %0d want 96", val_cnt - v0); end
      total++; if (xr_cnt - x0 !== 6) begin bad++; $display("FAIL px_right_edge: got %0d want 6", xr_cnt - x0); end
      total++; if (yb_cnt - y0 !== 16) begin bad++; $display("FAIL px_bottom_edge: got %0d want 16", yb_cnt - y0); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL px_locked: got %0b want 1", locked); end
   endtask

   task automatic test_long_line();
      int s0, f0, v0;
      s0 = serr_cnt; f0 = fs_cnt; v0 = val_cnt;
      send_frame(0, 8, 5, -1, -1);
      total++; if (serr_cnt !== s0 + 1) begin bad++; $display("FAIL long_serr_cnt: got %0d want %0d", serr_cnt, s0 + 1); end
      total++; if (serr_cyc !== line_start_cyc[9] + 2) begin bad++; $display("FAIL long_serr_time: got %0d want %0d", serr_cyc, line_start_cyc[9] + 2); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL long_locked: got %0b want 0", locked); end
      total++; if (val_cnt - v0 !== 64) begin bad++; $display("FAIL long_valid_cnt: got %0d want 64", val_cnt - v0); end
      total++; if (fs_cnt !== f0 + 1) begin bad++; $display("FAIL long_fs: got %0d want %0d", fs_cnt, f0 + 1); end
      send_frame(0, -1, 5, -1, -1);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_check_locked: got %0b want 0", locked); end
      total++; if (fs_cnt !== f0 + 1) begin bad++; $display("FAIL relock_check_fs: got %0d want %0d", fs_cnt, f0 + 1); end
      send_frame(0, -1, 5, -1, -1);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock_locked: got %0b want 1", locked); end
      total++; if (fs_cnt !== f0 + 2) begin bad++; $display("FAIL relock_fs: got %0d want %0d", fs_cnt, f0 + 2); end
      total++; if (serr_cnt !== s0 + 1) begin bad++; $display("FAIL relock_serr: got %0d want %0d", serr_cnt, s0 + 1); end
   endtask

   task automatic test_vs_offset();
      int s0, f0, v0;
      s0 = serr_cnt;
      do_reset();
      f0 = fs_cnt; v0 = val_cnt;
      send_frame(20, -1, 6, -1, -1);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL vsofs_f1_locked: got %0b want 0", locked); end
      send_frame(20, -1, 6, -1, -1);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL vsofs_locked: got %0b want 1", locked); end
      total++; if (lock_cyc !== line_start_cyc[1] + 2) begin bad++; $display("FAIL vsofs_lock_time: got %0d want %0d", lock_cyc, line_start_cyc[1] + 2); end
      total++; if (fs_cnt !== f0 + 1) begin bad++; $display("FAIL vsofs_fs: got %0d want %0d", fs_cnt, f0 + 1); end
      total++; if (fs_y !== 10'd0) begin bad++; $display("FAIL vsofs_y0: got %0d want 0", fs_y); end
      total++; if (fs_cyc !== tag_cyc + 3) begin bad++; $display("FAIL vsofs_fs_time: got %0d want %0d", fs_cyc, tag_cyc + 3); end
      total++; if (val_cnt - v0 !== 96) begin bad++; $display("FAIL vsofs_valid_cnt: got %0d want 96", val_cnt - v0); end
      total++; if (serr_cnt !== s0) begin bad++; $display("FAIL vsofs_serr: got %0d want %0d", serr_cnt, s0); end
   endtask

   task automatic test_hs_stuck();
      int s0;
      s0 = serr_cnt;
      repeat (2000) drive(1'b1, 1'b1, 12'h5A5);
      total++; if (serr_cnt !== s0 + 1) begin bad++; $display("FAIL stuck_serr_cnt: got %0d want %0d", serr_cnt, s0 + 1); end
      total++; if (serr_cyc !== line_start_cyc[13] + 1025) begin bad++; $display("FAIL stuck_serr_time: got %0d want %0d", serr_cyc, line_start_cyc[13] + 1025); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL stuck_locked: got %0b want 0", locked); end
   endtask

   task automatic test_reset_midline();
      int s0;
      do_reset();
      send_frame(0, -1, 5, -1, -1);
      send_frame(0, -1, 5, -1, -1);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL mid_pre_locked: got %0b want 1", locked); end
      s0 = serr_cnt;
      send_frame(0, -1, 5, 6, 12);
      @(negedge pixel_clk);
      total++; if (pix_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %0b want 1", pix_valid); end
      total++; if (X_pix !== 10'd2) begin bad++; $display("FAIL mid_pre_x: got %0d want 2", X_pix); end
      total++; if (Y_pix !== 10'd1) begin bad++; $display("FAIL mid_pre_y: got %0d want 1", Y_pix); end
      reset = 1'b1;
      @(negedge pixel_clk);
      total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %0b want 0", pix_valid); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_locked: got %0b want 0", locked); end
      total++; if (pixel_color !== 12'h000) begin bad++; $display("FAIL mid_color: got %h want 000", pixel_color); end
      total++; if (X_pix !== 10'd0) begin bad++; $display("FAIL mid_x: got %0d want 0", X_pix); end
      total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL mid_sync_err: got %0b want 0", sync_err); end
      reset = 1'b0;
      repeat (40) drive(1'b1, 1'b1, 12'h5A5);
      total++; if (serr_cnt !== s0) begin bad++; $display("FAIL mid_serr_cnt: got %0d want %0d", serr_cnt, s0); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_post_locked: got %0b want 0", locked); end
   endtask

   task automatic test_invariants();
      total++; if (viol !== 0) begin bad++; $display("FAIL invariants: got %0d violations want 0", viol); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_pixel();
      test_long_line();
      test_vs_offset();
      test_hs_stuck();
      test_reset_midline();
      test_invariants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
